// File: rtl/timer_pkg.sv
// Shared encodings for the kitchen-timer sequencing controller:
// state codes, button indices and status LED patterns.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LOAD  = 2;

    localparam logic [3:0] LED_IDLE      = 4'b0001;
    localparam logic [3:0] LED_RUN       = 4'b0010;
    localparam logic [3:0] LED_PAUSE     = 4'b0100;
    localparam logic [3:0] LED_ALARM     = 4'b1000;
    localparam logic [3:0] LED_FLASH_ON  = 4'b1111;
    localparam logic [3:0] LED_FLASH_OFF = 4'b0000;

    // One-hot state indication for the low LED nibble.
    function automatic logic [3:0] state_led(input state_t st);
        logic [3:0] led;
        case (st)
            ST_IDLE:  led = LED_IDLE;
            ST_RUN:   led = LED_RUN;
            ST_PAUSE: led = LED_PAUSE;
            ST_ALARM: led = LED_ALARM;
            default:  led = LED_IDLE;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, stability counter
// and a one-cycle registered pulse on each accepted press.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then accept a new level only after DB_CYCLES differing samples.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_MAX) begin
                    level_r <= sync2_r;
                    press_r <= sync2_r;
                    cnt_r   <= {CNT_W{1'b0}};
                end else begin
                    press_r <= 1'b0;
                    cnt_r   <= cnt_r + CNT_ONE;
                end
            end else begin
                press_r <= 1'b0;
                cnt_r   <= {CNT_W{1'b0}};
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/timer_ctrl.sv
// Kitchen-timer sequencing controller: button conditioning, IDLE/RUN/PAUSE/ALARM
// FSM, buzzer tone and status LEDs. Define TIMER_CTRL_ALARM_TIMEOUT_EN for alarm auto-stop.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int TONE_DIV  = 1000,
    parameter int ALARM_SEC = 30
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] PSW,
    input  logic       TICK,
    input  logic       ZERO,
    output logic       CNT_EN,
    output logic       LOAD,
    output logic       BZ,
    output logic [7:0] LED
);

    localparam int TONE_W = (TONE_DIV < 2) ? 1 : $clog2(TONE_DIV + 1);
    localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(TONE_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_ONE = TONE_W'(1);

    logic [3:0]        press_s;
    logic              start_s;
    logic              stop_s;
    logic              load_s;
    logic              spare_unused_s;
    logic              alarm_expire_s;

    state_t            state_r;
    logic              load_r;
    logic              bz_r;
    logic [3:0]        flash_r;
    logic [TONE_W-1:0] tone_cnt_r;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_btn_debounce (
            .CLOCK (CLOCK),
            .RESET (RESET),
            .raw   (PSW[gi]),
            .press (press_s[gi])
        );
    end

    assign start_s        = press_s[BTN_START];
    assign stop_s         = press_s[BTN_STOP];
    assign load_s         = press_s[BTN_LOAD];
    assign spare_unused_s = press_s[3];

`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
    localparam int TO_W = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(ALARM_SEC - 1);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    logic [TO_W-1:0] to_cnt_r;

    // Alarm ends on the ALARM_SEC-th TICK seen in ALARM.
    always_comb begin
        alarm_expire_s = 1'b0;
        if ((state_r == ST_ALARM) && TICK && (to_cnt_r == TO_MAX)) begin
            alarm_expire_s = 1'b1;
        end else begin
            alarm_expire_s = 1'b0;
        end
    end

    // Count TICKs while ringing; restart on every ALARM entry.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r != ST_ALARM) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (TICK) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    localparam int ALARM_SEC_UNUSED = ALARM_SEC;

    assign alarm_expire_s = 1'b0;
`endif

    // Main sequencer with registered LOAD pulse, tone and LED flash state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            load_r     <= 1'b0;
            bz_r       <= 1'b0;
            flash_r    <= LED_FLASH_OFF;
            tone_cnt_r <= {TONE_W{1'b0}};
        end else begin
            load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        if (!ZERO) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (load_s) begin
                        load_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Stop outranks reaching zero so an acknowledged stop never rings.
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                    end else if (ZERO) begin
                        state_r    <= ST_ALARM;
                        tone_cnt_r <= {TONE_W{1'b0}};
                        bz_r       <= 1'b0;
                        flash_r    <= LED_FLASH_ON;
                    end else if (start_s) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                    end else if (start_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_ALARM: begin
                    if (stop_s || alarm_expire_s) begin
                        state_r    <= ST_IDLE;
                        bz_r       <= 1'b0;
                        flash_r    <= LED_FLASH_OFF;
                        tone_cnt_r <= {TONE_W{1'b0}};
                    end else begin
                        if (tone_cnt_r == TONE_MAX) begin
                            tone_cnt_r <= {TONE_W{1'b0}};
                            bz_r       <= ~bz_r;
                        end else begin
                            tone_cnt_r <= tone_cnt_r + TONE_ONE;
                        end
                        if (TICK) begin
                            flash_r <= ~flash_r;
                        end else begin
                            flash_r <= flash_r;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    bz_r       <= 1'b0;
                    flash_r    <= LED_FLASH_OFF;
                    tone_cnt_r <= {TONE_W{1'b0}};
                end
            endcase
        end
    end

    // Gate combinationally so the counter chain stops in the very cycle 0:00 appears.
    assign CNT_EN = (state_r == ST_RUN) & ~ZERO;
    assign LOAD   = load_r;
    assign BZ     = bz_r;
    assign LED    = {flash_r, state_led(state_r)};

endmodule
